// File: rtl/insa_bounds_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// insa_bounds_ctrl_pkg
// Shared types and constants for the INSA bounds table controller.
//   INSA_NR_ENTRIES : default number of bounds table entries
//   insa_bounds_t   : one table entry {valid, first, last}
//   sweep_state_e   : controller state (IDLE / CLEAR sweep)
//   outOfBounds()   : true when an address falls outside a valid entry
// ---------------------------------------------------------------------------
package insa_bounds_ctrl_pkg;

  localparam int unsigned INSA_NR_ENTRIES = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] first;
    logic [31:0] last;
  } insa_bounds_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_e;

  // Unsigned compare; an entry stored with first > last makes every address
  // fall outside, so such an entry always reports a violation.
  function automatic logic outOfBounds(input insa_bounds_t entry,
                                       input logic [31:0] addr);
    return entry.valid && ((addr < entry.first) || (addr > entry.last));
  endfunction

endpackage

// File: rtl/insa_bounds_ctrl_if.sv
// ---------------------------------------------------------------------------
// insa_bounds_ctrl_if
// Groups the allocation handshake and the address-check request/response
// of the INSA bounds controller.
//   alloc_valid_i / alloc_ready_o   : allocation handshake
//   alloc_first_i / alloc_last_i    : bounds written on a fired allocation
//   alloc_idx_o                     : index the allocation lands in
//   chk_valid_i / chk_idx_i / chk_addr_i : check request
//   chk_valid_o / chk_violation_o   : check response, one cycle later
// Modports: slave = the controller, master = the requester (LSU/bench).
// ---------------------------------------------------------------------------
interface insa_bounds_ctrl_if #(
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
);

  logic             alloc_valid_i;
  logic             alloc_ready_o;
  logic [31:0]      alloc_first_i;
  logic [31:0]      alloc_last_i;
  logic [IDX_W-1:0] alloc_idx_o;

  logic             chk_valid_i;
  logic [IDX_W-1:0] chk_idx_i;
  logic [31:0]      chk_addr_i;
  logic             chk_valid_o;
  logic             chk_violation_o;

  modport slave (
    input  alloc_valid_i, alloc_first_i, alloc_last_i,
    output alloc_ready_o, alloc_idx_o,
    input  chk_valid_i, chk_idx_i, chk_addr_i,
    output chk_valid_o, chk_violation_o
  );

  modport master (
    output alloc_valid_i, alloc_first_i, alloc_last_i,
    input  alloc_ready_o, alloc_idx_o,
    output chk_valid_i, chk_idx_i, chk_addr_i,
    input  chk_valid_o, chk_violation_o
  );

endinterface

// File: rtl/insa_bounds_ctrl_lzc.sv
// ---------------------------------------------------------------------------
// insa_bounds_ctrl_lzc
// Leading/trailing zero counter in the style of common_cells lzc.
//   in_i    : input vector
//   cnt_o   : MODE=0 -> index of lowest set bit (trailing zero count)
//             MODE=1 -> number of leading zeros
//   empty_o : high when in_i has no bit set (cnt_o is then 0)
// ---------------------------------------------------------------------------
module insa_bounds_ctrl_lzc #(
  parameter int unsigned WIDTH = 16,
  parameter bit          MODE  = 1'b0,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Priority search written as a loop whose last hit wins, so the scan
  // direction decides whether the lowest or the highest set bit is reported.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) begin
          cnt_o   = CNT_W'(i);
          empty_o = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) begin
          cnt_o   = CNT_W'(WIDTH - 1 - i);
          empty_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/insa_bounds_ctrl.sv
// ---------------------------------------------------------------------------
// insa_bounds_ctrl
// Owns the INSA bounds table (NR_ENTRIES x {valid, first, last}), serves the
// ALU INSAFIRST/INSALAST read, sweeps the table clear on RSTBUF, latches the
// ENCRASH enable and checks LSU addresses, raising a sticky crash flag.
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   bus (slave)         : allocation handshake + address check req/rsp
//   alu_read_index_i    : entry index from the ALU immediate
//   alu_read_out_o/2_o  : first / last of that entry (0 if unusable)
//   rst_buf_i           : start (or restart) the table clear sweep
//   en_crash_i          : arm crash detection (sticky)
//   data_in_buffer_o    : at least one valid entry
//   busy_o              : clear sweep in progress
//   crash_o             : sticky crash flag
// ---------------------------------------------------------------------------
module insa_bounds_ctrl
  import insa_bounds_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = INSA_NR_ENTRIES,
  parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  insa_bounds_ctrl_if.slave    bus,
  input  logic [19:0]          alu_read_index_i,
  output logic [31:0]          alu_read_out_o,
  output logic [31:0]          alu_read_out2_o,
  input  logic                 rst_buf_i,
  input  logic                 en_crash_i,
  output logic                 data_in_buffer_o,
  output logic                 busy_o,
  output logic                 crash_o
);

  sweep_state_e            state_q, state_d;
  logic [IDX_W-1:0]        sweepPtr_q, sweepPtr_d;
  logic                    clearEn;

  logic [NR_ENTRIES-1:0]   validMask_q, validMask_d;
  logic [31:0]             firstMem_q [NR_ENTRIES];
  logic [31:0]             lastMem_q  [NR_ENTRIES];

  logic [IDX_W-1:0]        freeIdx;
  logic                    tableFull;
  logic                    allocFire;

  logic                    readInRange;
  logic [IDX_W-1:0]        readIdx;
  insa_bounds_t            aluEntry;
  insa_bounds_t            chkEntry;

  logic                    chkValid_q;
  logic                    chkViolation_q, chkViolation_d;
  logic                    enCrash_q;
  logic                    crash_q;

  // The lowest free slot is the lowest clear valid bit, found by counting
  // trailing zeros of the inverted mask; "empty" here means no free slot.
  insa_bounds_ctrl_lzc #(
    .WIDTH (NR_ENTRIES),
    .MODE  (1'b0),
    .CNT_W (IDX_W)
  ) u_free_lzc (
    .in_i    (~validMask_q),
    .cnt_o   (freeIdx),
    .empty_o (tableFull)
  );

  // State register for the clear sweep FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sweepPtr_q <= '0;
    end else begin
      state_q    <= state_d;
      sweepPtr_q <= sweepPtr_d;
    end
  end

  // Next-state logic: RSTBUF always (re)starts the sweep at entry 0; otherwise
  // the sweep walks one entry per cycle and ends after the last entry.
  always_comb begin
    state_d    = state_q;
    sweepPtr_d = sweepPtr_q;
    unique case (state_q)
      IDLE: begin
        if (rst_buf_i) begin
          state_d    = CLEAR;
          sweepPtr_d = '0;
        end
      end
      CLEAR: begin
        if (rst_buf_i) begin
          sweepPtr_d = '0;
        end else if (sweepPtr_q == IDX_W'(NR_ENTRIES - 1)) begin
          state_d    = IDLE;
          sweepPtr_d = '0;
        end else begin
          sweepPtr_d = sweepPtr_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        sweepPtr_d = '0;
      end
    endcase
  end

  // FSM outputs: every CLEAR cycle invalidates the entry under the pointer.
  always_comb begin
    busy_o  = 1'b0;
    clearEn = 1'b0;
    if (state_q == CLEAR) begin
      busy_o  = 1'b1;
      clearEn = 1'b1;
    end
  end

  // Allocation is only offered in IDLE and not in a cycle that starts a
  // sweep, so a write can never race the clear of the same entry.
  assign bus.alloc_ready_o = (state_q == IDLE) && !rst_buf_i && !tableFull;
  assign bus.alloc_idx_o   = freeIdx;
  assign allocFire         = bus.alloc_valid_i && bus.alloc_ready_o;

  // Valid mask next state; clear and allocate are mutually exclusive by state.
  always_comb begin
    validMask_d = validMask_q;
    if (clearEn) begin
      validMask_d[sweepPtr_q] = 1'b0;
    end
    if (allocFire) begin
      validMask_d[freeIdx] = 1'b1;
    end
  end

  // Valid bits are the only table state that needs a reset value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      validMask_q <= '0;
    end else begin
      validMask_q <= validMask_d;
    end
  end

  // Entry bounds storage; stored as given even when first > last.
  always_ff @(posedge clk_i) begin
    if (allocFire) begin
      firstMem_q[freeIdx] <= bus.alloc_first_i;
      lastMem_q[freeIdx]  <= bus.alloc_last_i;
    end
  end

  // Zero-latency ALU read; the full 20-bit index is range-checked before the
  // low bits are used so aliasing indices read as 0.
  always_comb begin
    readInRange = (alu_read_index_i < 20'(NR_ENTRIES));
    readIdx     = alu_read_index_i[IDX_W-1:0];
    aluEntry    = '{valid: validMask_q[readIdx],
                    first: firstMem_q[readIdx],
                    last:  lastMem_q[readIdx]};
    alu_read_out_o  = 32'h0;
    alu_read_out2_o = 32'h0;
    if (readInRange && aluEntry.valid && !busy_o) begin
      alu_read_out_o  = aluEntry.first;
      alu_read_out2_o = aluEntry.last;
    end
  end

  // Check uses the current table contents, so an allocation in the same
  // cycle is not yet visible; a check during the sweep never violates.
  always_comb begin
    chkEntry       = '{valid: validMask_q[bus.chk_idx_i],
                       first: firstMem_q[bus.chk_idx_i],
                       last:  lastMem_q[bus.chk_idx_i]};
    chkViolation_d = bus.chk_valid_i && !busy_o
                     && outOfBounds(chkEntry, bus.chk_addr_i);
  end

  // Check response pipeline plus crash arming. Crash looks at the already
  // registered violation and the already registered enable, so ENCRASH
  // arriving together with a visible violation does not crash.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chkValid_q     <= 1'b0;
      chkViolation_q <= 1'b0;
      enCrash_q      <= 1'b0;
      crash_q        <= 1'b0;
    end else begin
      chkValid_q     <= bus.chk_valid_i;
      chkViolation_q <= chkViolation_d;
      enCrash_q      <= enCrash_q || en_crash_i;
      crash_q        <= crash_q || (chkViolation_q && enCrash_q);
    end
  end

  assign bus.chk_valid_o     = chkValid_q;
  assign bus.chk_violation_o = chkViolation_q;
  assign crash_o             = crash_q;
  assign data_in_buffer_o    = |validMask_q;

endmodule
